// File: rtl/seven_segment_mux.sv
// -----------------------------------------------------------------------------
// seven_segment_mux
//
// Multi-digit BCD up/down counter with a time-multiplexed seven-segment driver.
// A prescaler turns the fast system clock into count steps. A second,
// free-running counter rotates a one-hot digit enable across the display. The
// shared segment bus carries the glyph of whichever digit is currently lit.
//
// Parameters:
//   DIGITS      number of BCD digits (1..8)
//   TICK_DIV    clk cycles per count step (>= 2)
//   REFRESH_DIV clk cycles each digit stays lit (>= 2)
//   ACTIVE_LOW  1 inverts seg_o and digit_o (common-anode displays)
//   LZB         1 blanks leading zero digits; digit 0 is never blanked
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   en        in   count enable; low freezes the prescaler and the value
//   up        in   1 = count up, 0 = count down, sampled at each step
//   load      in   parallel load strobe (wins over a coincident step)
//   load_val  in   BCD load value, digit 0 in bits [3:0]; nibbles > 9 load as 0
//   seg_o     out  segments {g,f,e,d,c,b,a}, registered
//   digit_o   out  one-hot digit enable, registered
//   value_o   out  current BCD value
//   wrap_o    out  one-cycle pulse when the counter wraps
// -----------------------------------------------------------------------------
module seven_segment_mux #(
    parameter int DIGITS      = 4,
    parameter int TICK_DIV    = 10_000_000,
    parameter int REFRESH_DIV = 10_000,
    parameter int ACTIVE_LOW  = 0,
    parameter int LZB         = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     digit_o,
    output logic [4*DIGITS-1:0]   value_o,
    output logic                  wrap_o
);

    // -------------------------------------------------------------------------
    // Derived widths and constants
    // -------------------------------------------------------------------------
    localparam int VAL_W  = 4 * DIGITS;
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = $clog2(REFRESH_DIV);
    // A single-digit display still needs a one-bit index to keep the
    // selection logic uniform; it simply never leaves 0.
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    localparam logic              INV       = (ACTIVE_LOW != 0);
    localparam logic              LZB_EN    = (LZB != 0);
    localparam logic [6:0]        SEG_POL   = {7{INV}};
    localparam logic [DIGITS-1:0] DIG_POL   = {DIGITS{INV}};
    localparam logic [6:0]        GLYPH_0   = 7'b0111111;
    localparam logic [DIGITS-1:0] DIG_FIRST = DIGITS'(1);

    // -------------------------------------------------------------------------
    // Glyph table, active-high, bit order {g,f,e,d,c,b,a}
    // -------------------------------------------------------------------------
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b0111111;
            4'd1:    glyph = 7'b0000110;
            4'd2:    glyph = 7'b1011011;
            4'd3:    glyph = 7'b1001111;
            4'd4:    glyph = 7'b1100110;
            4'd5:    glyph = 7'b1101101;
            4'd6:    glyph = 7'b1111100;
            4'd7:    glyph = 7'b0000111;
            4'd8:    glyph = 7'b1111111;
            4'd9:    glyph = 7'b1100111;
            default: glyph = 7'b0000000;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [VAL_W-1:0]  value;
    logic [TICK_W-1:0] tick_cnt;
    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  digit_idx;

    // -------------------------------------------------------------------------
    // Load value clean-up: any non-BCD nibble is stored as 0
    // -------------------------------------------------------------------------
    logic [VAL_W-1:0] load_clean;

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path through the block can leave it unassigned (latch).
    always_comb begin
        load_clean = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (load_val[4*k +: 4] <= 4'd9) begin
                load_clean[4*k +: 4] = load_val[4*k +: 4];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next value for a count step. A ripple carry (up) or borrow (down) starts
    // at digit 0; a carry that survives past the top digit means the counter
    // went from all-9s to all-0s (or the reverse), i.e. it wrapped.
    // -------------------------------------------------------------------------
    logic [VAL_W-1:0] step_val;
    logic             step_wrap;
    logic             carry;
    logic [3:0]       nib;

    always_comb begin
        step_val = value;
        carry    = 1'b1;
        nib      = '0;
        for (int k = 0; k < DIGITS; k++) begin
            nib = value[4*k +: 4];
            if (carry) begin
                if (up) begin
                    if (nib == 4'd9) begin
                        step_val[4*k +: 4] = 4'd0;
                    end else begin
                        step_val[4*k +: 4] = nib + 4'd1;
                        carry              = 1'b0;
                    end
                end else begin
                    if (nib == 4'd0) begin
                        step_val[4*k +: 4] = 4'd9;
                    end else begin
                        step_val[4*k +: 4] = nib - 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end
        step_wrap = carry;
    end

    // -------------------------------------------------------------------------
    // Prescaler and counter. Load clears the prescaler so the next step is a
    // full TICK_DIV enabled cycles away, and it suppresses a coincident step
    // (including its wrap pulse).
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value    <= '0;
            tick_cnt <= '0;
            wrap_o   <= 1'b0;
        end else begin
            wrap_o <= 1'b0;
            if (load) begin
                value    <= load_clean;
                tick_cnt <= '0;
            end else if (en) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt <= '0;
                    value    <= step_val;
                    wrap_o   <= step_wrap;
                end else begin
                    tick_cnt <= tick_cnt + TICK_W'(1);
                end
            end
        end
    end

    assign value_o = value;

    // -------------------------------------------------------------------------
    // Scan counter: runs regardless of en so the display keeps refreshing
    // while the count is frozen.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt  <= '0;
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Leading-zero blanking: blank_vec[k] is set when digit k and every digit
    // above it are zero. Bit 0 stays clear so a value of 0 still shows "0".
    // -------------------------------------------------------------------------
    logic [DIGITS-1:0] blank_vec;
    logic              run_zero;

    always_comb begin
        blank_vec = '0;
        run_zero  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run_zero     = run_zero & (value[4*k +: 4] == 4'd0);
            blank_vec[k] = run_zero & LZB_EN;
        end
    end

    // -------------------------------------------------------------------------
    // Select the lit digit. A compare-per-digit mux keeps the index width
    // independent of DIGITS not being a power of two.
    // -------------------------------------------------------------------------
    logic [3:0]        cur_nib;
    logic              cur_blank;
    logic [6:0]        seg_raw;
    logic [DIGITS-1:0] digit_raw;

    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (digit_idx == IDX_W'(k)) begin
                cur_nib   = value[4*k +: 4];
                cur_blank = blank_vec[k];
            end
        end
        seg_raw   = cur_blank ? 7'b0000000 : glyph(cur_nib);
        digit_raw = DIG_FIRST << digit_idx;
    end

    // -------------------------------------------------------------------------
    // Output registers. Segments and digit enable load on the same edge from
    // the same index, so the display never shows one digit's glyph under
    // another digit's enable. Polarity is applied here, so reset drives the
    // same physical "digit 0 showing 0" pattern as normal operation would.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_o   <= GLYPH_0 ^ SEG_POL;
            digit_o <= DIG_FIRST ^ DIG_POL;
        end else begin
            seg_o   <= seg_raw ^ SEG_POL;
            digit_o <= digit_raw ^ DIG_POL;
        end
    end

endmodule

// File: tb/tb_seven_segment_mux.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_mux
//
// Self-checking bench for seven_segment_mux with DIGITS=2, TICK_DIV=4,
// REFRESH_DIV=3, ACTIVE_LOW=0, LZB=1. The reference model keeps the count as
// a plain integer 0..99 and derives digits, glyphs and blanking from decimal
// arithmetic; it advances once per rising edge using the driven inputs.
// -----------------------------------------------------------------------------
module tb_seven_segment_mux;

    localparam int DIGITS      = 2;
    localparam int TICK_DIV    = 4;
    localparam int REFRESH_DIV = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic       up    = 1'b1;
    logic       load  = 1'b0;
    logic [7:0] load_val = '0;
    logic [6:0] seg_o;
    logic [1:0] digit_o;
    logic [7:0] value_o;
    logic       wrap_o;

    seven_segment_mux #(
        .DIGITS      (DIGITS),
        .TICK_DIV    (TICK_DIV),
        .REFRESH_DIV (REFRESH_DIV),
        .ACTIVE_LOW  (0),
        .LZB         (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .seg_o    (seg_o),
        .digit_o  (digit_o),
        .value_o  (value_o),
        .wrap_o   (wrap_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------------------------------------------------------- model
    int         m_val;   // count as an ordinary integer, 0..99
    int         m_tick;  // enabled cycles since the last step or load
    int         m_scan;  // cycles the current digit has been lit
    int         m_idx;   // which digit is lit
    logic       m_wrap;
    logic [6:0] m_seg;
    logic [1:0] m_dig;

    function automatic logic [6:0] glyph_of(int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111100;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1100111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int from_load(logic [7:0] lv);
        int lo;
        int hi;
        lo = int'(lv[3:0]);
        hi = int'(lv[7:4]);
        if (lo > 9) lo = 0;
        if (hi > 9) hi = 0;
        return hi * 10 + lo;
    endfunction

    task automatic model_reset();
        m_val  = 0;
        m_tick = 0;
        m_scan = 0;
        m_idx  = 0;
        m_wrap = 1'b0;
        m_seg  = glyph_of(0);
        m_dig  = 2'b01;
    endtask

    // One rising edge: display registers capture the pre-edge value/index,
    // then count and scan advance.
    task automatic model_edge();
        int lo;
        int hi;
        lo    = m_val % 10;
        hi    = m_val / 10;
        m_dig = 2'(1 << m_idx);
        if (m_idx == 0)   m_seg = glyph_of(lo);
        else if (hi == 0) m_seg = 7'b0000000;
        else              m_seg = glyph_of(hi);

        m_wrap = 1'b0;
        if (load) begin
            m_val  = from_load(load_val);
            m_tick = 0;
        end else if (en) begin
            if (m_tick == TICK_DIV - 1) begin
                m_tick = 0;
                if (up) begin
                    m_wrap = (m_val == 99);
                    m_val  = (m_val + 1) % 100;
                end else begin
                    m_wrap = (m_val == 0);
                    m_val  = (m_val + 99) % 100;
                end
            end else begin
                m_tick++;
            end
        end

        if (m_scan == REFRESH_DIV - 1) begin
            m_scan = 0;
            m_idx  = (m_idx + 1) % DIGITS;
        end else begin
            m_scan++;
        end
    endtask

    function automatic logic [17:0] exp_vec();
        return {to_bcd(m_val), m_seg, m_dig, m_wrap};
    endfunction

    function automatic logic [17:0] act_vec();
        return {value_o, seg_o, digit_o, wrap_o};
    endfunction

    function automatic string fmt(logic [17:0] v);
        return $sformatf("val=%h seg=%b dig=%b wrap=%b", v[17:10], v[9:3], v[2:1], v[0]);
    endfunction

    // Advance one clock and sample 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        logic [17:0] rst_vec;
        rst_vec = {8'h00, 7'b0111111, 2'b01, 1'b0};
        #2 rst_n = 1'b0;
        model_reset();
        #10;
        n_cmp++;
        if (act_vec() !== rst_vec) begin
            n_bad++;
            $display("FAIL reset_hold: got %s, want %s", fmt(act_vec()), fmt(rst_vec));
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_cmp++;
        if (act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_release: got %s, want %s", fmt(act_vec()), fmt(exp_vec()));
        end
    endtask

    task automatic test_count_up();
        logic [7:0] prev;
        int         changes;
        en      = 1'b1;
        up      = 1'b1;
        changes = 0;
        prev    = value_o;
        for (int i = 0; i < 40; i++) begin
            cycle();
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL count_up cyc %0d: got %s, want %s", i, fmt(act_vec()), fmt(exp_vec()));
            end
            if (value_o !== prev) changes++;
            prev = value_o;
        end
        n_cmp++;
        if (value_o !== 8'h10 || changes != 10) begin
            n_bad++;
            $display("FAIL count_up_total: got val=%h steps=%0d, want val=10 steps=10", value_o, changes);
        end
    endtask

    task automatic test_wrap_up();
        int wraps;
        wraps    = 0;
        up       = 1'b1;
        load     = 1'b1;
        load_val = 8'h99;
        cycle();
        load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL wrap_up cyc %0d: got %s, want %s", i, fmt(act_vec()), fmt(exp_vec()));
            end
            if (wrap_o === 1'b1) wraps++;
            if (i == 3) begin
                n_cmp++;
                if (value_o !== 8'h00 || wrap_o !== 1'b1) begin
                    n_bad++;
                    $display("FAIL wrap_up_step: got val=%h wrap=%b, want val=00 wrap=1", value_o, wrap_o);
                end
            end
        end
        n_cmp++;
        if (wraps != 1) begin
            n_bad++;
            $display("FAIL wrap_up_pulse: got %0d wrap cycles, want 1", wraps);
        end
    endtask

    task automatic test_wrap_down();
        int wraps;
        wraps    = 0;
        load     = 1'b1;
        load_val = 8'h00;
        cycle();
        load = 1'b0;
        up   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL wrap_down cyc %0d: got %s, want %s", i, fmt(act_vec()), fmt(exp_vec()));
            end
            if (wrap_o === 1'b1) wraps++;
            if (i == 3) begin
                n_cmp++;
                if (value_o !== 8'h99 || wrap_o !== 1'b1) begin
                    n_bad++;
                    $display("FAIL wrap_down_step: got val=%h wrap=%b, want val=99 wrap=1", value_o, wrap_o);
                end
            end
        end
        n_cmp++;
        if (value_o !== 8'h98 || wraps != 1) begin
            n_bad++;
            $display("FAIL wrap_down_next: got val=%h wraps=%0d, want val=98 wraps=1", value_o, wraps);
        end
        up = 1'b1;
    endtask

    task automatic test_scan_blank();
        logic [1:0] prev_dig;
        int         toggles;
        en       = 1'b0;
        load     = 1'b1;
        load_val = 8'h05;
        cycle();
        load     = 1'b0;
        toggles  = 0;
        cycle();
        prev_dig = digit_o;
        for (int i = 0; i < 12; i++) begin
            cycle();
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL scan cyc %0d: got %s, want %s", i, fmt(act_vec()), fmt(exp_vec()));
            end
            n_cmp++;
            if (!((digit_o === 2'b01 && seg_o === 7'b1101101) ||
                  (digit_o === 2'b10 && seg_o === 7'b0000000))) begin
                n_bad++;
                $display("FAIL scan_glyph cyc %0d: got dig=%b seg=%b, want 01/1101101 or 10/0000000",
                         i, digit_o, seg_o);
            end
            if (digit_o !== prev_dig) toggles++;
            prev_dig = digit_o;
        end
        n_cmp++;
        if (toggles != 4) begin
            n_bad++;
            $display("FAIL scan_rate: got %0d digit changes in 12 cycles, want 4", toggles);
        end
    endtask

    task automatic test_load_collision();
        en = 1'b1;
        up = 1'b1;
        for (int i = 0; i < 2 * TICK_DIV && m_tick != TICK_DIV - 1; i++) cycle();
        load     = 1'b1;
        load_val = 8'h3F;
        cycle();
        load = 1'b0;
        n_cmp++;
        if (value_o !== 8'h30 || wrap_o !== 1'b0) begin
            n_bad++;
            $display("FAIL load_collide: got val=%h wrap=%b, want val=30 wrap=0", value_o, wrap_o);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_cmp++;
            if (value_o !== ((i == 3) ? 8'h31 : 8'h30) || act_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL load_next_step cyc %0d: got %s, want %s", i, fmt(act_vec()), fmt(exp_vec()));
            end
        end
    endtask

    task automatic test_enable_hold();
        logic [7:0] held;
        en = 1'b1;
        cycle();
        cycle();
        en   = 1'b0;
        held = to_bcd(m_val);
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_cmp++;
            if (value_o !== held || act_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL en_hold cyc %0d: got %s, want %s", i, fmt(act_vec()), fmt(exp_vec()));
            end
        end
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL en_resume cyc %0d: got %s, want %s", i, fmt(act_vec()), fmt(exp_vec()));
            end
        end
    endtask

    task automatic test_async_reset();
        logic [17:0] rst_vec;
        rst_vec = {8'h00, 7'b0111111, 2'b01, 1'b0};
        en = 1'b1;
        up = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (act_vec() !== rst_vec) begin
            n_bad++;
            $display("FAIL async_reset: got %s, want %s", fmt(act_vec()), fmt(rst_vec));
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < TICK_DIV; i++) begin
            cycle();
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL post_reset cyc %0d: got %s, want %s", i, fmt(act_vec()), fmt(exp_vec()));
            end
        end
        n_cmp++;
        if (value_o !== 8'h01) begin
            n_bad++;
            $display("FAIL post_reset_step: got val=%h, want 01", value_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            up       = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 19) == 0);
            load_val = 8'($urandom);
            cycle();
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc %0d: got %s, want %s", i, fmt(act_vec()), fmt(exp_vec()));
            end
        end
        load = 1'b0;
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_scan_blank();
        test_load_collision();
        test_enable_hold();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
